// File: rtl/neuron_mac_bank.sv
// neuron_mac_bank: per-neuron weight store with a multiply-accumulate, ReLU and saturation engine.
//   clk          rising-edge clock
//   reset        synchronous active-high reset
//   write        weight write strobe; writes wr_data into weight w[unit_sel][unit_address]
//   unit_sel     neuron index of the write
//   unit_address weight index of the write
//   wr_data      signed weight value
//   x_in         packed layer inputs; x[k] = x_in[k*DATA_W +: DATA_W]
//   sum_trigger  starts a pass; it is sampled only while the engine is idle
//   busy         high while the MAC or ACT phase is in progress
//   out_valid    one-cycle pulse after y_out has been updated
//   y_out        packed results; y[u] = y_out[u*DATA_W +: DATA_W]
module neuron_mac_bank #(
  parameter int N_UNITS   = 4,
  parameter int N_INPUTS  = 4,
  parameter int DATA_W    = 8,
  parameter int FRAC_BITS = 4,
  parameter int ACC_W     = 18,
  parameter int UNIT_W    = $clog2(N_UNITS),
  parameter int ADDR_W    = $clog2(N_INPUTS)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         write,
  input  logic [UNIT_W-1:0]            unit_sel,
  input  logic [ADDR_W-1:0]            unit_address,
  input  logic [DATA_W-1:0]            wr_data,
  input  logic [N_INPUTS*DATA_W-1:0]   x_in,
  input  logic                         sum_trigger,
  output logic                         busy,
  output logic                         out_valid,
  output logic [N_UNITS*DATA_W-1:0]    y_out
);
  typedef enum logic [1:0] {IDLE, MAC, ACT} state_t;
  localparam logic signed [ACC_W-1:0] Y_MAX = ACC_W'(2**(DATA_W-1)-1);
  state_t state, state_next;
  logic signed [DATA_W-1:0]   w [N_UNITS][N_INPUTS];
  logic signed [DATA_W-1:0]   x_reg [N_INPUTS];
  logic signed [ACC_W-1:0]    acc [N_UNITS];
  logic signed [2*DATA_W-1:0] prod [N_UNITS];
  logic signed [ACC_W-1:0]    t [N_UNITS];
  logic [DATA_W-1:0]          y_next [N_UNITS];
  logic [ADDR_W-1:0]          k;
  assign busy = state != IDLE;
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_next;
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = sum_trigger ? MAC : IDLE;
      MAC:     state_next = k == ADDR_W'(N_INPUTS-1) ? ACT : MAC;
      default: state_next = IDLE;
    endcase
  end
  // Full-width signed products and the clamped activation for every neuron.
  always_comb
    for (int u = 0; u < N_UNITS; u++) begin
      prod[u] = w[u][k] * x_reg[k];
      t[u] = acc[u] >>> FRAC_BITS;
      y_next[u] = acc[u][ACC_W-1] ? '0 : t[u] > Y_MAX ? Y_MAX[DATA_W-1:0] : t[u][DATA_W-1:0];
    end
  // A write landing at the same edge as a MAC step does not reach that step's
  // read, so only weights not yet consumed see it.
  always_ff @(posedge clk)
    if (reset) begin
      for (int u = 0; u < N_UNITS; u++)
        for (int i = 0; i < N_INPUTS; i++)
          w[u][i] <= '0;
    end else if (write)
      w[unit_sel][unit_address] <= wr_data;
  always_ff @(posedge clk)
    if (reset) begin
      for (int i = 0; i < N_INPUTS; i++)
        x_reg[i] <= '0;
      for (int u = 0; u < N_UNITS; u++)
        acc[u] <= '0;
      k <= '0;
      y_out <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= state == ACT;
      case (state)
        IDLE:
          if (sum_trigger) begin
            for (int i = 0; i < N_INPUTS; i++)
              x_reg[i] <= x_in[i*DATA_W +: DATA_W];
            for (int u = 0; u < N_UNITS; u++)
              acc[u] <= '0;
            k <= '0;
          end
        MAC: begin
          for (int u = 0; u < N_UNITS; u++)
            acc[u] <= acc[u] + ACC_W'(prod[u]);
          k <= k + 1'b1;
        end
        default:
          for (int u = 0; u < N_UNITS; u++)
            y_out[u*DATA_W +: DATA_W] <= y_next[u];
      endcase
    end
endmodule

// File: tb/tb_neuron_mac_bank.sv
// tb_neuron_mac_bank: randomized and directed scoreboard bench for neuron_mac_bank.
module tb_neuron_mac_bank;
  logic clk = 0, reset = 1, write = 0, sum_trigger = 0;
  logic [1:0] unit_sel = 0, unit_address = 0;
  logic [7:0] wr_data = 0;
  logic [31:0] x_in = 0;
  logic busy, out_valid;
  logic [31:0] y_out;
  int passed = 0, total = 0;
  logic signed [7:0] mw [4][4];
  logic signed [7:0] snap [4][4];
  logic [31:0] xs;
  int ph = 0;
  logic ov_exp = 0;
  logic [31:0] exp_q [$];
  always #5 clk = ~clk;
  neuron_mac_bank dut (
    .clk(clk), .reset(reset), .write(write), .unit_sel(unit_sel),
    .unit_address(unit_address), .wr_data(wr_data), .x_in(x_in),
    .sum_trigger(sum_trigger), .busy(busy), .out_valid(out_valid), .y_out(y_out)
  );
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask
  // y[u] = clamp(sum_k w*x / 16, 0, 127), computed with plain integers.
  function automatic logic [31:0] model(input logic signed [7:0] wm [4][4], input logic [31:0] x);
    logic [31:0] y = 0;
    for (int u = 0; u < 4; u++) begin
      int s = 0;
      for (int i = 0; i < 4; i++) begin
        logic signed [7:0] xv = x[i*8 +: 8];
        s += int'(wm[u][i]) * int'(xv);
      end
      y[u*8 +: 8] = s < 0 ? 8'd0 : (s / 16 > 127 ? 8'd127 : 8'(s / 16));
    end
    return y;
  endfunction
  // ph counts edges since the trigger was accepted; a write at ph=j reaches
  // the pass only for weight indices >= j (not yet consumed).
  task automatic step(input logic rst, input logic wr, input logic [1:0] us, input logic [1:0] ua,
                      input logic [7:0] d, input logic trig, input logic [31:0] x);
    reset = rst; write = wr; unit_sel = us; unit_address = ua; wr_data = d;
    sum_trigger = trig; x_in = x;
    @(posedge clk);
    ov_exp = 0;
    if (rst) begin
      for (int u = 0; u < 4; u++)
        for (int i = 0; i < 4; i++)
          mw[u][i] = 0;
      ph = 0;
    end else begin
      if (wr) begin
        mw[us][ua] = d;
        if (ph != 0 && int'(ua) >= ph) snap[us][ua] = d;
      end
      if (ph == 0) begin
        if (trig) begin
          snap = mw;
          xs = x;
          ph = 1;
        end
      end else if (ph == 5) begin
        exp_q.push_back(model(snap, xs));
        ov_exp = 1;
        ph = 0;
      end else ph++;
    end
    #1;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic wr_w(input logic [1:0] u, input logic [1:0] i, input logic [7:0] d);
    step(0, 1, u, i, d, 0, 0);
  endtask
  task automatic trig(input logic [31:0] x);
    step(0, 0, 0, 0, 0, 1, x);
  endtask
  always @(negedge clk) begin
    check("busy", 32'(busy), 32'(ph != 0));
    check("out_valid", 32'(out_valid), 32'(ov_exp));
    if (out_valid) begin
      if (exp_q.size() == 0) check("unexpected_result", 32'(out_valid), 32'd0);
      else check("y_out", y_out, exp_q.pop_front());
    end
  end
  initial begin
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    check("reset_y", y_out, 32'd0);
    trig(32'h5a3c7f11);
    idle(7);
    check("no_weights_y", y_out, 32'd0);
    for (int i = 0; i < 4; i++) wr_w(0, 2'(i), 8'd16);
    trig({8'd0, 8'hf0, 8'd32, 8'd16});
    idle(7);
    check("basic_y0", 32'(y_out[7:0]), 32'd32);
    for (int i = 0; i < 4; i++) wr_w(1, 2'(i), 8'hf0);
    wr_w(2, 0, 8'd1);
    trig({8'd16, 8'd16, 8'd16, 8'd15});
    idle(7);
    check("relu_y1", 32'(y_out[15:8]), 32'd0);
    check("trunc_y2", 32'(y_out[23:16]), 32'd0);
    for (int i = 0; i < 4; i++) wr_w(3, 2'(i), 8'd127);
    trig({4{8'd127}});
    idle(7);
    check("sat_y3", 32'(y_out[31:24]), 32'd127);
    for (int i = 0; i < 4; i++) wr_w(0, 2'(i), 8'h80);
    trig({4{8'h80}});
    idle(7);
    check("sat_y0", 32'(y_out[7:0]), 32'd127);
    step(0, 1, 3, 0, 8'd50, 1, {4{8'd20}});
    step(0, 0, 0, 0, 0, 1, 0);
    idle(7);
    for (int i = 0; i < 14; i++) trig({4{8'(i * 3)}});
    idle(7);
    trig({4{8'd40}});
    idle(1);
    step(1, 0, 0, 0, 0, 0, 0);
    idle(7);
    check("reset_mid_y", y_out, 32'd0);
    trig({4{8'd77}});
    idle(7);
    check("cleared_weights_y", y_out, 32'd0);
    for (int n = 0; n < 500; n++)
      step($urandom_range(0, 99) == 0, $urandom_range(0, 1) == 1, 2'($urandom), 2'($urandom),
           8'($urandom), $urandom_range(0, 3) == 0, $urandom);
    idle(8);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
